// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encoding, default widths and the request payload.
// Used by the ALU, the decoder and the ALU arbiter.
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OP_WIDTH   = 4;

  localparam logic [OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [OP_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [OP_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [OP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [OP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [OP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [OP_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [OP_WIDTH-1:0] ALU_AND  = 4'd9;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus between the requesters, the ALU arbiter and the ALU instance.
//   req_*      : per-requester valid/ready handshake and packed op/operands
//   rsp_*      : one-hot response pulse and result back to the owner
//   alu_*      : registered op/operands to the ALU, combinational result back
// modport slave  : the arbiter side
// modport master : the environment side (requesters + ALU)
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = alu_pkg::OP_WIDTH,
  parameter int unsigned NUM_REQ    = 2
);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*OP_WIDTH-1:0]   req_op_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]         rsp_data_o;
  logic [OP_WIDTH-1:0]           alu_op_o;
  logic [DATA_WIDTH-1:0]         alu_a_o;
  logic [DATA_WIDTH-1:0]         alu_b_o;
  logic [DATA_WIDTH-1:0]         alu_result_i;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, alu_result_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, alu_op_o, alu_a_o, alu_b_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, alu_result_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, alu_op_o, alu_a_o, alu_b_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid request at or after
// the pointer (wrapping); pointer moves past the winner, holds when idle.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : request vector
//   gnt_c         : one-hot grant (combinational)
//   gnt_id_c      : index of the winner (combinational)
//   gnt_valid_c   : any grant this cycle (combinational)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]    gnt_id_c,
  output logic               gnt_valid_c
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] idx;

  // Cyclic priority search starting at the pointer
  always_comb begin
    gnt_c       = '0;
    gnt_id_c    = '0;
    gnt_valid_c = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_valid_c && req_i[idx]) begin
        gnt_valid_c = 1'b1;
        gnt_c[idx]  = 1'b1;
        gnt_id_c    = idx;
      end
    end
  end

  // Pointer moves one past the winner so it gets lowest priority next
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (gnt_valid_c) begin
      ptr_q <= (32'(gnt_id_c) == NUM_REQ - 1) ? '0 : gnt_id_c + ID_W'(1);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters. Round-robin accept
// every cycle, stage 1 registers the winner's op/operands into the ALU, stage 2
// captures the result and pulses a one-hot response to the owner.
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : alu_arbiter_if.slave (requests, responses, ALU side)
//   grant_cnt_o   : per-requester saturating accept counters, only when
//                   ALU_ARB_PERF_EN is defined
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = alu_pkg::OP_WIDTH,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  alu_arbiter_if.slave       bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0] grant_cnt_o
`endif
);

  import alu_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    gnt_c;
  logic [ID_W-1:0]       gnt_id_c;
  logic                  gnt_valid_c;
  logic [OP_WIDTH-1:0]   win_op_c;
  logic [DATA_WIDTH-1:0] win_a_c;
  logic [DATA_WIDTH-1:0] win_b_c;
  logic                  s1_valid_q;
  logic [ID_W-1:0]       s1_id_q;
  logic [NUM_REQ-1:0]    s1_onehot_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (bus.req_valid_i),
    .gnt_c       (gnt_c),
    .gnt_id_c    (gnt_id_c),
    .gnt_valid_c (gnt_valid_c)
  );

  assign bus.req_ready_o = gnt_c;

  // AND-OR select of the granted requester's payload
  always_comb begin
    win_op_c = '0;
    win_a_c  = '0;
    win_b_c  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        win_op_c = bus.req_op_i[i*OP_WIDTH +: OP_WIDTH];
        win_a_c  = bus.req_a_i[i*DATA_WIDTH +: DATA_WIDTH];
        win_b_c  = bus.req_b_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Stage 1: ALU input registers only load on an accept so idle cycles don't toggle the ALU
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      bus.alu_op_o <= '0;
      bus.alu_a_o  <= '0;
      bus.alu_b_o  <= '0;
    end else begin
      s1_valid_q <= gnt_valid_c;
      if (gnt_valid_c) begin
        s1_id_q      <= gnt_id_c;
        bus.alu_op_o <= win_op_c;
        bus.alu_a_o  <= win_a_c;
        bus.alu_b_o  <= win_b_c;
      end
    end
  end

  always_comb begin
    s1_onehot_c          = '0;
    s1_onehot_c[s1_id_q] = 1'b1;
  end

  // Stage 2: capture the ALU result; data holds between responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.rsp_valid_o <= '0;
      bus.rsp_data_o  <= '0;
    end else begin
      bus.rsp_valid_o <= s1_valid_q ? s1_onehot_c : '0;
      if (s1_valid_q) begin
        bus.rsp_data_o <= bus.alu_result_i;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [31:0] cnt_q [NUM_REQ];

  // Saturating per-requester accept counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_c[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_o[i*32 +: 32] = cnt_q[i];
    end
  end
`endif

endmodule
